// File: rtl/rgb_colours_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_colours_pkg
//  Brief    : Shared geometry constants, bar colour table entries and pixel
//             type for the 800x600 test-pattern generator.
//  Revision : 1.0 - initial release
// ============================================================================
package rgb_colours_pkg;

  // Visible area and pattern band geometry
  localparam int H_VISIBLE    = 800;
  localparam int V_VISIBLE    = 600;
  localparam int BAR_WIDTH    = 100;
  localparam int BAR_END_ROW  = 400;
  localparam int RAMP_END_ROW = 500;
  localparam int CHECK_BIT    = 5;

  // One pixel packed as {R,G,B}, 8 bits per channel
  typedef logic [23:0] pixel_t;

  // Colour bar palette, left to right
  localparam pixel_t COL_WHITE   = 24'hFF_FF_FF;
  localparam pixel_t COL_YELLOW  = 24'hFF_FF_00;
  localparam pixel_t COL_CYAN    = 24'h00_FF_FF;
  localparam pixel_t COL_GREEN   = 24'h00_FF_00;
  localparam pixel_t COL_MAGENTA = 24'hFF_00_FF;
  localparam pixel_t COL_RED     = 24'hFF_00_00;
  localparam pixel_t COL_BLUE    = 24'h00_00_FF;
  localparam pixel_t COL_BLACK   = 24'h00_00_00;

endpackage : rgb_colours_pkg
`default_nettype wire

// File: rtl/rgb_bar_lut.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_bar_lut
//  Brief    : Combinational lookup from 3-bit colour bar index to 24-bit
//             {R,G,B} colour.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_bar_lut
  import rgb_colours_pkg::*;
(
  input  logic [2:0]  bar_idx,
  output logic [23:0] colour
);

  // Map each bar index onto its palette entry
  always_comb begin
    colour = COL_BLACK;
    case (bar_idx)
      3'd0:    colour = COL_WHITE;
      3'd1:    colour = COL_YELLOW;
      3'd2:    colour = COL_CYAN;
      3'd3:    colour = COL_GREEN;
      3'd4:    colour = COL_MAGENTA;
      3'd5:    colour = COL_RED;
      3'd6:    colour = COL_BLUE;
      default: colour = COL_BLACK;
    endcase
  end

endmodule : rgb_bar_lut
`default_nettype wire

// File: rtl/rgb_colours.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_colours
//  Brief    : Test-pattern pixel generator for the 800x600 VGA path. Colour
//             bars (rows 0-399), grey ramp (rows 400-499) and checkerboard
//             (rows 500-599); black outside the visible area. Registered
//             outputs, one clock of latency.
//  Options  : RGB_COLOURS_GRID_EN - overlay a white grid on the visible area
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_colours
  import rgb_colours_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  reset_count_rgb,
  input  logic [10:0] count_rgb,
  output logic [7:0]  red_1,
  output logic [7:0]  green_1,
  output logic [7:0]  blue_1
);

  logic        w_visible;
  logic [2:0]  w_bar_idx;
  logic [23:0] w_bar_colour;
  logic [9:0]  w_y_off;
  logic        w_cell;
  logic        w_grid;
  pixel_t      w_pixel;
  pixel_t      r_pixel;

  assign w_visible = (count_rgb < 11'(H_VISIBLE)) && (reset_count_rgb < 10'(V_VISIBLE));

  // Bar index by comparison against multiples of the bar width so the
  // boundaries land exactly on x = 100, 200, ... 700
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (count_rgb >= 11'(BAR_WIDTH * k)) w_bar_idx = 3'(k);
    end
  end

  rgb_bar_lut u_bar_lut (
    .bar_idx (w_bar_idx),
    .colour  (w_bar_colour)
  );

  // Checkerboard is referenced to the top of its band; never negative there
  assign w_y_off = reset_count_rgb - 10'(RAMP_END_ROW);
  assign w_cell  = count_rgb[CHECK_BIT] ^ w_y_off[CHECK_BIT];

`ifdef RGB_COLOURS_GRID_EN
  // Grid lines on every bar boundary plus the right/bottom visible edges
  always_comb begin
    w_grid = (count_rgb == 11'(H_VISIBLE - 1)) ||
             (reset_count_rgb == 10'(V_VISIBLE - 1));
    for (int k = 0; k < 8; k++) begin
      if (count_rgb == 11'(BAR_WIDTH * k)) w_grid = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      if (reset_count_rgb == 10'(BAR_WIDTH * k)) w_grid = 1'b1;
    end
  end
`else
  assign w_grid = 1'b0;
`endif

  // Region select: blanking first, then grid overlay, then the row band
  always_comb begin
    w_pixel = COL_BLACK;
    if (!w_visible) begin
      w_pixel = COL_BLACK;
    end else if (w_grid) begin
      w_pixel = COL_WHITE;
    end else if (reset_count_rgb < 10'(BAR_END_ROW)) begin
      w_pixel = w_bar_colour;
    end else if (reset_count_rgb < 10'(RAMP_END_ROW)) begin
      w_pixel = {3{count_rgb[9:2]}};
    end else begin
      w_pixel = w_cell ? COL_BLACK : COL_WHITE;
    end
  end

  // Output register; reset drives black immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pixel <= COL_BLACK;
    else        r_pixel <= w_pixel;
  end

  assign red_1   = r_pixel[23:16];
  assign green_1 = r_pixel[15:8];
  assign blue_1  = r_pixel[7:0];

endmodule : rgb_colours
`default_nettype wire

// File: tb/tb_rgb_colours.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_colours
//  Brief    : Self-checking bench for rgb_colours. Expected pixels are queued
//             when coordinates are driven and compared one clock later.
//  Options  : RGB_COLOURS_GRID_EN - bench expectations follow the overlay
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_colours;

  logic        clk;
  logic        rst_n;
  logic [9:0]  reset_count_rgb;
  logic [10:0] count_rgb;
  logic [7:0]  red_1;
  logic [7:0]  green_1;
  logic [7:0]  blue_1;

  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_q[$];
  string       tag_q[$];

  rgb_colours dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .reset_count_rgb (reset_count_rgb),
    .count_rgb       (count_rgb),
    .red_1           (red_1),
    .green_1         (green_1),
    .blue_1          (blue_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_pixel(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // White grid override applied on top of the plain pattern when compiled in
  function automatic logic [23:0] with_grid(input int x, input int y, input logic [23:0] base);
    logic [23:0] r;
    r = base;
`ifdef RGB_COLOURS_GRID_EN
    if (x < 800 && y < 600 &&
        ((x % 100 == 0) || x == 799 || (y % 100 == 0) || y == 599))
      r = 24'hFFFFFF;
`endif
    return r;
  endfunction

  // Drive one coordinate pair before the next rising edge and queue its result
  task automatic drive(input string tag, input int x, input int y, input logic [23:0] base);
    @(negedge clk);
    count_rgb       = 11'(x);
    reset_count_rgb = 10'(y);
    exp_q.push_back(with_grid(x, y, base));
    tag_q.push_back(tag);
  endtask

  // Scoreboard: compare the head of the queue just after each rising edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check_pixel(tag_q.pop_front(), {red_1, green_1, blue_1}, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n           = 1'b0;
    count_rgb       = 11'd50;
    reset_count_rgb = 10'd50;
    repeat (3) @(posedge clk);
    #1;
    check_pixel("rst_hold", {red_1, green_1, blue_1}, 24'h000000);

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(with_grid(50, 50, 24'hFFFFFF));
    tag_q.push_back("rst_release");

    // Bar boundaries
    drive("bar_x99",   99, 10, 24'hFFFFFF);
    drive("bar_x100", 100, 10, 24'hFFFF00);
    drive("bar_x199", 199, 10, 24'hFFFF00);
    drive("bar_x200", 200, 10, 24'h00FFFF);
    drive("bar_x350", 350, 10, 24'h00FF00);
    drive("bar_x450", 450, 10, 24'hFF00FF);
    drive("bar_x550", 550, 10, 24'hFF0000);
    drive("bar_x650", 650, 10, 24'h0000FF);
    drive("bar_x799", 799, 10, 24'h000000);
    drive("bar_y399", 450, 399, 24'hFF00FF);

    // Grey ramp
    drive("ramp_x0",     0, 450, 24'h000000);
    drive("ramp_x400", 400, 450, 24'h646464);
    drive("ramp_x799", 799, 450, 24'hC7C7C7);
    drive("ramp_x300", 300, 450, 24'h4B4B4B);
    drive("ramp_y400",   7, 400, 24'h010101);

    // Checkerboard
    drive("chk_y510_x10", 10, 510, 24'hFFFFFF);
    drive("chk_y510_x40", 40, 510, 24'h000000);
    drive("chk_y540_x10", 10, 540, 24'h000000);
    drive("chk_y540_x40", 40, 540, 24'hFFFFFF);

    // Blanking and wrap
    drive("blank_x800",   800,  10, 24'h000000);
    drive("blank_x1040", 1040,   0, 24'h000000);
    drive("blank_y600",    10, 600, 24'h000000);
    drive("blank_y666",   100, 666, 24'h000000);
    drive("grid_x800",    800, 100, 24'h000000);
    drive("blank_y700",   450, 700, 24'h000000);
    drive("wrap_x0y0",      0,   0, 24'hFFFFFF);

    // Asynchronous reset mid-frame, then recovery on the first edge
    drive("pre_rst", 10, 10, 24'hFFFFFF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_pixel("rst_async", {red_1, green_1, blue_1}, 24'h000000);
    @(posedge clk);
    #1;
    check_pixel("rst_hold_mid", {red_1, green_1, blue_1}, 24'h000000);
    @(negedge clk);
    rst_n           = 1'b1;
    count_rgb       = 11'd450;
    reset_count_rgb = 10'd10;
    exp_q.push_back(with_grid(450, 10, 24'hFF00FF));
    tag_q.push_back("rst_recover");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rgb_colours
`default_nettype wire
